// File: rtl/uart_command_master.sv
// Initiator for the UART settings-access protocol: serialises register requests and parses responses.
// Define UART_COMMAND_MASTER_CHECKSUM_EN to append an XOR checksum byte to frames and responses.
module uart_command_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int BUFFER_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic [BUFFER_WIDTH-1:0] tx_data,
    output logic                    tx_write,
    input  logic                    tx_full,
    input  logic [BUFFER_WIDTH-1:0] rx_data,
    output logic                    rx_read,
    input  logic                    rx_empty,
    output logic                    busy
);

    localparam logic [BUFFER_WIDTH-1:0] CMD_WRITE = BUFFER_WIDTH'(8'h57);
    localparam logic [BUFFER_WIDTH-1:0] CMD_READ  = BUFFER_WIDTH'(8'h52);
    localparam logic [BUFFER_WIDTH-1:0] ACK_BYTE  = BUFFER_WIDTH'(8'h4B);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, SEND_CMD, SEND_ADDR, SEND_DH, SEND_DL, WAIT_R0, WAIT_R1, RESP
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
        , SEND_CS, WAIT_CS
`endif
    } state_t;

    // Where the frame and the response parse go once the payload bytes are done.
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
    localparam state_t FRAME_END = SEND_CS;
    localparam state_t RESP_END  = WAIT_CS;
`else
    localparam state_t FRAME_END = WAIT_R0;
    localparam state_t RESP_END  = RESP;
`endif

    state_t                  state_q, state_d;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    accept;
    logic                    in_wait;
    logic                    timeout_hit;
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
    logic [BUFFER_WIDTH-1:0] txcs_q;
    logic [BUFFER_WIDTH-1:0] rxcs_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Counter restarts on every wait-state entry and every popped byte.
            if (!in_wait || rx_read) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_write    = 1'b0;
        tx_data     = '0;
        rx_read     = 1'b0;
        accept      = 1'b0;
        in_wait     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = SEND_CMD;
                end
            end
            SEND_CMD: begin
                tx_data = write_q ? CMD_WRITE : CMD_READ;
                if (!tx_full) begin
                    tx_write = 1'b1;
                    state_d  = SEND_ADDR;
                end
            end
            SEND_ADDR: begin
                tx_data = BUFFER_WIDTH'(addr_q);
                if (!tx_full) begin
                    tx_write = 1'b1;
                    state_d  = write_q ? SEND_DH : FRAME_END;
                end
            end
            SEND_DH: begin
                tx_data = BUFFER_WIDTH'(wdata_q[DATA_WIDTH-1 -: 8]);
                if (!tx_full) begin
                    tx_write = 1'b1;
                    state_d  = SEND_DL;
                end
            end
            SEND_DL: begin
                tx_data = BUFFER_WIDTH'(wdata_q[7:0]);
                if (!tx_full) begin
                    tx_write = 1'b1;
                    state_d  = FRAME_END;
                end
            end
            WAIT_R0: begin
                in_wait = 1'b1;
                if (!rx_empty) begin
                    rx_read = 1'b1;
                    state_d = write_q ? RESP_END : WAIT_R1;
                end else if (cnt_q == CNT_LIMIT) begin
                    timeout_hit = 1'b1;
                    state_d     = RESP;
                end
            end
            WAIT_R1: begin
                in_wait = 1'b1;
                if (!rx_empty) begin
                    rx_read = 1'b1;
                    state_d = RESP_END;
                end else if (cnt_q == CNT_LIMIT) begin
                    timeout_hit = 1'b1;
                    state_d     = RESP;
                end
            end
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
            SEND_CS: begin
                tx_data = txcs_q;
                if (!tx_full) begin
                    tx_write = 1'b1;
                    state_d  = WAIT_R0;
                end
            end
            WAIT_CS: begin
                in_wait = 1'b1;
                if (!rx_empty) begin
                    rx_read = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_LIMIT) begin
                    timeout_hit = 1'b1;
                    state_d     = RESP;
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture and response assembly; outputs are gated by state so these need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
        if (rx_read) begin
            case (state_q)
                WAIT_R0: begin
                    if (write_q) begin
                        if (rx_data != ACK_BYTE) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        rdata_q[DATA_WIDTH-1 -: 8] <= rx_data[7:0];
                    end
                end
                WAIT_R1: begin
                    rdata_q[7:0] <= rx_data[7:0];
                end
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
                WAIT_CS: begin
                    if (rx_data != rxcs_q) begin
                        err_q <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
        if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
        end
    end

`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
    // Running XOR of bytes sent in this frame and of response bytes received before the checksum.
    always_ff @(posedge clk) begin
        if (accept) begin
            txcs_q <= '0;
            rxcs_q <= '0;
        end else begin
            if (tx_write) begin
                txcs_q <= txcs_q ^ tx_data;
            end
            if (rx_read && (state_q != WAIT_CS)) begin
                rxcs_q <= rxcs_q ^ rx_data;
            end
        end
    end
`endif

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_error = rsp_valid & err_q;

endmodule

// File: tb/tb_uart_command_master.sv
// Bench for uart_command_master: FIFO-modelled UART side, table vectors, corner sequences and random traffic.
module tb_uart_command_master;

    localparam int TO = 64;
    typedef logic [7:0] bq_t [$];

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [15:0] wd;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          nb;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_full = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_read;
    logic        rx_empty = 1'b1;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bq_t         rx_q;
    logic [7:0]  tx_log [$];
    int          tx_cyc [$];
    logic        rsp_seen = 1'b0;
    logic [15:0] rsp_rd = 16'h0;
    logic        rsp_er = 1'b0;
    int          rsp_cyc = 0;
    logic        ready_due = 1'b0;

    uart_command_master #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .BUFFER_WIDTH(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
        .rx_data(rx_data), .rx_read(rx_read), .rx_empty(rx_empty),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rx_refresh();
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    endtask

    // Frame the master should emit, built straight from the protocol description.
    function automatic bq_t exp_frame(input logic w, input logic [7:0] a, input logic [15:0] wd);
        bq_t f;
        if (w) f = '{8'h57, a, wd[15:8], wd[7:0]};
        else   f = '{8'h52, a};
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            foreach (f[i]) x ^= f[i];
            f.push_back(x);
        end
`endif
        return f;
    endfunction

    // Expected {error, rdata} for a given set of injected response bytes.
    function automatic logic [16:0] exp_rsp(input logic w, input bq_t rb);
        int          need = w ? 1 : 2;
        logic [15:0] d = 16'h0;
        logic        e = 1'b0;
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
        need++;
`endif
        if (rb.size() < need) return {1'b1, 16'h0};
        if (w) e = (rb[0] != 8'h4B);
        else   d = {rb[0], rb[1]};
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            for (int i = 0; i < need - 1; i++) x ^= rb[i];
            if (rb[need-1] != x) e = 1'b1;
        end
`endif
        return {e, d};
    endfunction

    // UART-side monitor: samples mid-cycle, pops the modelled RX FIFO just after the edge.
    initial begin
        logic pop;
        forever begin
            @(negedge clk);
            pop = rx_read;
            if (ready_due) begin
                chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
                ready_due = 1'b0;
            end
            if (tx_write) begin
                chk("tx_write_while_full", 32'(tx_full), 32'd0);
                tx_log.push_back(tx_data);
                tx_cyc.push_back(cyc);
            end
            if (rx_read) chk("rx_read_while_empty", 32'(rx_empty), 32'd0);
            if (rsp_valid) begin
                rsp_seen  = 1'b1;
                rsp_rd    = rsp_rdata;
                rsp_er    = rsp_error;
                rsp_cyc   = cyc;
                ready_due = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pop && rx_q.size() > 0) begin
                void'(rx_q.pop_front());
                rx_refresh();
            end
        end
    end

    task automatic run_txn(input logic w, input logic [7:0] a, input logic [15:0] wd,
                           input bq_t rb, input int stall_at, input int stall_len,
                           output int acc, output logic got);
        bq_t fr;
        int  n;
        int  idx;
        bit  pushed;
        fr = exp_frame(w, a, wd);
        n = fr.size();
        tx_log.delete();
        tx_cyc.delete();
        rsp_seen = 1'b0;
        got = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        for (int t = 0; t < 50 && !req_ready; t++) begin
            @(posedge clk);
            #1;
        end
        if (!req_ready) begin
            chk("req_ready_wait", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            acc = cyc;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        chk("req_ready_drop", 32'(req_ready), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        pushed = 0;
        for (int t = 0; t < 300 && !got; t++) begin
            idx = cyc - acc;
            if (stall_at >= 0 && idx == stall_at) tx_full = 1'b1;
            if (stall_at >= 0 && idx == stall_at + stall_len) tx_full = 1'b0;
            if (!pushed && tx_log.size() == n) begin
                foreach (rb[i]) rx_q.push_back(rb[i]);
                rx_refresh();
                pushed = 1;
            end
            @(posedge clk);
            #1;
            got = rsp_seen;
        end
        tx_full = 1'b0;
        if (!got) chk("rsp_wait_bound", 32'(got), 32'd1);
        chk("tx_count", 32'(tx_log.size()), 32'(n));
        for (int i = 0; i < n && i < tx_log.size(); i++) begin
            chk($sformatf("tx_byte%0d", i), 32'(tx_log[i]), 32'(fr[i]));
            if (stall_at < 0) chk($sformatf("tx_cycle%0d", i), 32'(tx_cyc[i]), 32'(acc + i));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vt [4];
        bq_t         rb;
        int          acc;
        logic        got;
        logic        w;
        logic [7:0]  a;
        logic [15:0] wd;
        logic [16:0] e;

        vt[0] = '{1'b1, 8'h10, 16'hA55A, 8'h4B, 8'h00, 1, 16'h0000, 1'b0};
        vt[1] = '{1'b0, 8'h00, 16'h0000, 8'h12, 8'h34, 2, 16'h1234, 1'b0};
        vt[2] = '{1'b1, 8'h33, 16'hBEEF, 8'h4E, 8'h00, 1, 16'h0000, 1'b1};
        vt[3] = '{1'b0, 8'hFF, 16'h0000, 8'hAB, 8'hCD, 2, 16'hABCD, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_tx_write", 32'(tx_write), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rx_read", 32'(rx_read), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++) begin
            rb.delete();
            rb.push_back(vt[k].b0);
            if (vt[k].nb > 1) rb.push_back(vt[k].b1);
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
            rb.push_back(vt[k].nb > 1 ? (vt[k].b0 ^ vt[k].b1) : vt[k].b0);
`endif
            run_txn(vt[k].w, vt[k].a, vt[k].wd, rb, -1, 0, acc, got);
            chk($sformatf("vec%0d_rdata", k), 32'(rsp_rd), 32'(vt[k].exp_rdata));
            chk($sformatf("vec%0d_error", k), 32'(rsp_er), 32'(vt[k].exp_err));
        end

        // Back-pressure while the data-high byte is pending.
        rb.delete();
        rb.push_back(8'h4B);
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
        rb.push_back(8'h4B);
`endif
        run_txn(1'b1, 8'h44, 16'hC3D2, rb, 2, 20, acc, got);
        if (tx_cyc.size() >= 4) begin
            chk("stall_dh_cycle", 32'(tx_cyc[2]), 32'(acc + 22));
            chk("stall_dl_cycle", 32'(tx_cyc[3]), 32'(acc + 23));
        end else begin
            chk("stall_tx_count", 32'(tx_cyc.size()), 32'd4);
        end
        chk("stall_error", 32'(rsp_er), 32'd0);

        // Read with no reply at all.
        rb.delete();
        run_txn(1'b0, 8'h42, 16'h0000, rb, -1, 0, acc, got);
        chk("timeout_error", 32'(rsp_er), 32'd1);
        chk("timeout_rdata", 32'(rsp_rd), 32'd0);
        chk("timeout_cycle", 32'(rsp_cyc), 32'(acc + exp_frame(1'b0, 8'h42, 16'h0).size() + TO));

        // Reset mid-frame, then a fresh request.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h21;
        req_wdata = 16'h1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_tx_write", 32'(tx_write), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rb = '{8'h5A, 8'hC3};
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
        rb.push_back(8'h5A ^ 8'hC3);
`endif
        run_txn(1'b0, 8'h07, 16'h0000, rb, -1, 0, acc, got);
        chk("after_rst_rdata", 32'(rsp_rd), 32'h5AC3);
        chk("after_rst_error", 32'(rsp_er), 32'd0);

        // Random traffic against the reference model.
        for (int k = 0; k < 16; k++) begin
            w  = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            wd = 16'($urandom);
            rb.delete();
            if (w) rb.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h4B);
            else begin
                rb.push_back(8'($urandom));
                rb.push_back(8'($urandom));
            end
`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
            begin
                logic [7:0] x = 8'h00;
                foreach (rb[i]) x ^= rb[i];
                if ($urandom_range(0, 3) == 0) x = x ^ 8'h01;
                rb.push_back(x);
            end
`endif
            e = exp_rsp(w, rb);
            run_txn(w, a, wd, rb, -1, 0, acc, got);
            chk($sformatf("rand%0d_rdata", k), 32'(rsp_rd), 32'(e[15:0]));
            chk($sformatf("rand%0d_error", k), 32'(rsp_er), 32'(e[16]));
        end

`ifdef UART_COMMAND_MASTER_CHECKSUM_EN
        rb = '{8'h12, 8'h34, 8'h26};
        run_txn(1'b0, 8'h05, 16'h0000, rb, -1, 0, acc, got);
        if (tx_log.size() == 3) chk("cs_frame_byte", 32'(tx_log[2]), 32'h57);
        chk("cs_good_rdata", 32'(rsp_rd), 32'h1234);
        chk("cs_good_error", 32'(rsp_er), 32'd0);
        rb = '{8'h12, 8'h34, 8'h00};
        run_txn(1'b0, 8'h05, 16'h0000, rb, -1, 0, acc, got);
        chk("cs_bad_rdata", 32'(rsp_rd), 32'h1234);
        chk("cs_bad_error", 32'(rsp_er), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
